// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter: round-robin sharing of one floating-point divider among four
// requesters. Sequences the divider reset per operation, masks a stale DONE
// level on the first RUN cycle and returns a quiet NaN if the divider never
// answers within TIMEOUT cycles.
module fpdiv_arbiter #(
  parameter int unsigned TIMEOUT = 100,
  parameter logic [31:0] QNAN    = 32'h7FC00000
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [3:0]   req,
  input  logic [127:0] opa,
  input  logic [127:0] opb,
  output logic [3:0]   ack,
  output logic [31:0]  res_data,
  output logic [1:0]   res_exc,
  output logic [1:0]   res_id,
  output logic         res_timeout,
  output logic         busy,
  output logic [31:0]  div_a,
  output logic [31:0]  div_b,
  output logic         div_rst,
  input  logic         div_done,
  input  logic [31:0]  div_result,
  input  logic [1:0]   div_exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gid_q, gid_d;
  logic [3:0]  ack_q, ack_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_exc_q, res_exc_d;
  logic [1:0]  res_id_q, res_id_d;
  logic        res_timeout_q, res_timeout_d;
  logic        busy_q, busy_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_rst_q, div_rst_d;

  logic [31:0] opa_w [4];
  logic [31:0] opb_w [4];
  logic [1:0]  win;
  logic [1:0]  cand;
  logic        found;

  // Unpack the per-requester operand lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign opa_w[gi] = opa[32*gi +: 32];
      assign opb_w[gi] = opb[32*gi +: 32];
    end
  endgenerate

  // Round-robin winner: first set request at or above ptr, wrapping 3 -> 0.
  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic; outputs follow the next state.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gid_d         = gid_q;
    ack_d         = 4'b0000;
    res_data_d    = res_data_q;
    res_exc_d     = res_exc_q;
    res_id_d      = res_id_q;
    res_timeout_d = res_timeout_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          div_a_d = opa_w[win];
          div_b_d = opb_w[win];
          gid_d   = win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = 8'd0;
        state_d = RUN;
      end
      RUN: begin
        // A DONE seen on the first RUN cycle is left over from the last job.
        if (div_done && (cnt_q != 8'd0)) begin
          res_data_d    = div_result;
          res_exc_d     = div_exc;
          res_timeout_d = 1'b0;
          res_id_d      = gid_q;
          ack_d         = 4'b0001 << gid_q;
          state_d       = RESP;
        end else if (cnt_q == TIMEOUT_CNT) begin
          res_data_d    = QNAN;
          res_exc_d     = 2'b11;
          res_timeout_d = 1'b1;
          res_id_d      = gid_q;
          ack_d         = 4'b0001 << gid_q;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        ptr_d   = gid_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    div_rst_d = (state_d != RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      cnt_q         <= 8'd0;
      gid_q         <= 2'd0;
      ack_q         <= 4'b0000;
      res_data_q    <= 32'd0;
      res_exc_q     <= 2'd0;
      res_id_q      <= 2'd0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      div_a_q       <= 32'd0;
      div_b_q       <= 32'd0;
      div_rst_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      gid_q         <= gid_d;
      ack_q         <= ack_d;
      res_data_q    <= res_data_d;
      res_exc_q     <= res_exc_d;
      res_id_q      <= res_id_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      div_rst_q     <= div_rst_d;
    end
  end

  assign ack         = ack_q;
  assign res_data    = res_data_q;
  assign res_exc     = res_exc_q;
  assign res_id      = res_id_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_rst     = div_rst_q;

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed bench for fpdiv_arbiter with a small divider model.
module tb_fpdiv_arbiter;

  logic         CLOCK;
  logic         RESET;
  logic [3:0]   req;
  logic [127:0] opa;
  logic [127:0] opb;
  logic [3:0]   ack;
  logic [31:0]  res_data;
  logic [1:0]   res_exc;
  logic [1:0]   res_id;
  logic         res_timeout;
  logic         busy;
  logic [31:0]  div_a;
  logic [31:0]  div_b;
  logic         div_rst;
  logic         div_done;
  logic [31:0]  div_result;
  logic [1:0]   div_exc;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mcnt  = 0;
  int model_k;
  logic stale_en;

  fpdiv_arbiter dut (
    .CLOCK(CLOCK), .RESET(RESET), .req(req), .opa(opa), .opb(opb),
    .ack(ack), .res_data(res_data), .res_exc(res_exc), .res_id(res_id),
    .res_timeout(res_timeout), .busy(busy), .div_a(div_a), .div_b(div_b),
    .div_rst(div_rst), .div_done(div_done), .div_result(div_result),
    .div_exc(div_exc)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Divider model: counts cycles out of reset, raises DONE at count model_k
  // (0 = never). stale_en keeps DONE high while held in reset and on the
  // first cycle out of reset, like a leftover level from the previous job.
  always @(posedge CLOCK) begin
    if (div_rst !== 1'b0) mcnt <= 0;
    else                  mcnt <= mcnt + 1;
  end

  always_comb begin
    div_done = (stale_en && ((div_rst !== 1'b0) || (mcnt == 0))) ||
               ((div_rst === 1'b0) && (model_k != 0) && (mcnt == model_k));
    if (div_a == 32'h40400000 && div_b == 32'h40000000) begin
      div_result = 32'h3FC00000;
      div_exc    = 2'b00;
    end else begin
      div_result = div_a + div_b;
      div_exc    = div_b[1:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Wait for the next grant, then its ack; check the response and latency.
  task automatic run_op(input string tag, input logic [3:0] e_ack, input logic [1:0] e_id,
                        input logic [31:0] e_data, input logic [1:0] e_exc, input logic e_to,
                        input int e_lat, input logic [3:0] req_after, input int k_after);
    int n;
    int cb;
    int ca;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge CLOCK); n++; end
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge CLOCK); n++; end
    chk({tag, ":granted"}, {31'd0, busy}, 32'd1);
    cb = cyc;
    n = 0;
    while (ack === 4'b0000 && n < 400) begin @(negedge CLOCK); n++; end
    ca = cyc;
    $display("op %s: ack=%b id=%0d data=%h exc=%b to=%b lat=%0d",
             tag, ack, res_id, res_data, res_exc, res_timeout, ca - cb + 1);
    chk({tag, ":ack"},     {28'd0, ack},         {28'd0, e_ack});
    chk({tag, ":id"},      {30'd0, res_id},      {30'd0, e_id});
    chk({tag, ":data"},    res_data,             e_data);
    chk({tag, ":exc"},     {30'd0, res_exc},     {30'd0, e_exc});
    chk({tag, ":timeout"}, {31'd0, res_timeout}, {31'd0, e_to});
    chk({tag, ":latency"}, ca - cb + 1,          e_lat);
    req     = req_after;
    model_k = k_after;
    @(negedge CLOCK);
    chk({tag, ":ack_one_cycle"}, {28'd0, ack}, 32'd0);
    chk({tag, ":busy_after"},    {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int cb;
    RESET    = 1'b1;
    req      = 4'b0000;
    opa      = {32'h44440000, 32'h33330000, 32'h22220000, 32'h11110000};
    opb      = {32'h00004000, 32'h00000303, 32'h00000022, 32'h00000001};
    model_k  = 0;
    stale_en = 1'b0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);

    // Reset state
    chk("rst:ack",     {28'd0, ack},         32'd0);
    chk("rst:data",    res_data,             32'd0);
    chk("rst:exc",     {30'd0, res_exc},     32'd0);
    chk("rst:id",      {30'd0, res_id},      32'd0);
    chk("rst:timeout", {31'd0, res_timeout}, 32'd0);
    chk("rst:busy",    {31'd0, busy},        32'd0);
    chk("rst:div_a",   div_a,                32'd0);
    chk("rst:div_b",   div_b,                32'd0);
    chk("rst:div_rst", {31'd0, div_rst},     32'd1);

    // Single request: 3.0 / 2.0 = 1.5, done at k=30
    opa[31:0] = 32'h40400000;
    opb[31:0] = 32'h40000000;
    model_k   = 30;
    RESET     = 1'b0;
    req       = 4'b0001;
    run_op("single", 4'b0001, 2'd0, 32'h3FC00000, 2'b00, 1'b0, 33, 4'b0000, 3);
    opa[31:0] = 32'h11110000;
    opb[31:0] = 32'h00000001;

    // Simultaneous requests held from reset release
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    req   = 4'b1111;
    run_op("all0", 4'b0001, 2'd0, 32'h11110001, 2'b01, 1'b0, 6, 4'b1111, 3);
    run_op("all1", 4'b0010, 2'd1, 32'h22220022, 2'b10, 1'b0, 6, 4'b1111, 3);
    run_op("all2", 4'b0100, 2'd2, 32'h33330303, 2'b11, 1'b0, 6, 4'b1111, 3);
    run_op("all3", 4'b1000, 2'd3, 32'h44444000, 2'b00, 1'b0, 6, 4'b1001, 3);
    run_op("pair0", 4'b0001, 2'd0, 32'h11110001, 2'b01, 1'b0, 6, 4'b1001, 3);
    run_op("pair3", 4'b1000, 2'd3, 32'h44444000, 2'b00, 1'b0, 6, 4'b0110, 3);

    // Fairness between requesters 1 and 2
    run_op("fair1a", 4'b0010, 2'd1, 32'h22220022, 2'b10, 1'b0, 6, 4'b0110, 3);
    run_op("fair2a", 4'b0100, 2'd2, 32'h33330303, 2'b11, 1'b0, 6, 4'b0110, 3);
    run_op("fair1b", 4'b0010, 2'd1, 32'h22220022, 2'b10, 1'b0, 6, 4'b0110, 3);
    run_op("fair2b", 4'b0100, 2'd2, 32'h33330303, 2'b11, 1'b0, 6, 4'b0011, 0);

    // Timeout, then the next requester served normally
    run_op("tmo0", 4'b0001, 2'd0, 32'h7FC00000, 2'b11, 1'b1, 103, 4'b0011, 4);
    run_op("after_tmo1", 4'b0010, 2'd1, 32'h22220022, 2'b10, 1'b0, 7, 4'b1100, 5);

    // Stale DONE level masked on the first RUN cycle
    stale_en = 1'b1;
    run_op("stale2", 4'b0100, 2'd2, 32'h33330303, 2'b11, 1'b0, 8, 4'b1100, 5);
    run_op("stale3", 4'b1000, 2'd3, 32'h44444000, 2'b00, 1'b0, 8, 4'b0010, 4);
    stale_en = 1'b0;

    // Reset in the middle of requester 2's operation (ptr = 2 at that point)
    run_op("pre_rst1", 4'b0010, 2'd1, 32'h22220022, 2'b10, 1'b0, 7, 4'b0110, 30);
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge CLOCK); n++; end
    chk("midrst:granted", {31'd0, busy}, 32'd1);
    cb = cyc;
    repeat (11) @(negedge CLOCK);
    chk("midrst:cnt10_busy", {31'd0, busy}, 32'd1);
    chk("midrst:cnt10_gid",  div_a,         32'h33330000);
    RESET = 1'b1;
    @(negedge CLOCK);
    $display("reset at run count %0d: busy=%b div_rst=%b ack=%b", cyc - cb - 2, busy, div_rst, ack);
    chk("midrst:busy",    {31'd0, busy},    32'd0);
    chk("midrst:div_rst", {31'd0, div_rst}, 32'd1);
    chk("midrst:ack",     {28'd0, ack},     32'd0);
    chk("midrst:div_a",   div_a,            32'd0);
    RESET   = 1'b0;
    model_k = 4;
    // ptr back at 0, so requester 1 wins before the abandoned requester 2
    run_op("regrant1", 4'b0010, 2'd1, 32'h22220022, 2'b10, 1'b0, 7, 4'b0110, 4);
    run_op("regrant2", 4'b0100, 2'd2, 32'h33330303, 2'b11, 1'b0, 7, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
